// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared constants and helpers for the APB request path
//
// Purpose: default bus widths and the requester-index width helper used by
// the arbiter, its ID queue and the command-bus interface.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 16;
  localparam int APB_DATA_WIDTH = 16;

  // Bits needed to hold an index in 0..n-1; never less than one bit so a
  // degenerate count still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// rtl/apb_req_arbiter_if.sv - command/response bus between arbiter and APB master queue
//
// Purpose: bundles the forwarded command and the transfer-complete return.
// Signals:
//   m_req/m_rw/m_addr/m_wdata : command toward the master queue
//   m_ready                   : master queue can accept
//   m_done/m_rdata/m_err      : transfer-complete pulse with read data and PSLVERR
// Modports: master = arbiter side (issues commands), slave = master-queue side.
interface apb_req_arbiter_if
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH
);

  logic                  m_req;
  logic                  m_rw;
  logic [ADDR_WIDTH-1:0] m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic                  m_ready;
  logic                  m_done;
  logic [DATA_WIDTH-1:0] m_rdata;
  logic                  m_err;

  modport master (
    output m_req, m_rw, m_addr, m_wdata,
    input  m_ready, m_done, m_rdata, m_err
  );

  modport slave (
    input  m_req, m_rw, m_addr, m_wdata,
    output m_ready, m_done, m_rdata, m_err
  );

endinterface

// File: rtl/apb_id_fifo.sv
// rtl/apb_id_fifo.sv - in-order queue of requester IDs awaiting a response
//
// Purpose: remembers which requester owns each accepted-but-unanswered
// transfer so completions can be routed back in issue order.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_push, i_push_data : enqueue (ignored when full, even alongside a pop)
//   i_pop               : dequeue (ignored when empty)
//   o_head              : oldest entry
//   o_full, o_empty, o_count : occupancy, count exact over 0..DEPTH
module apb_id_fifo
  import apb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

  // Full blocks a push even when a pop happens in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; only pointers define validity.
  always_ff @(posedge i_clock) begin
    if (w_push) r_mem[r_wptr] <= i_push_data;
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// rtl/apb_req_arbiter.sv - round-robin funnel of requesters into one APB master queue
//
// Purpose: picks one requester per cycle (round-robin), forwards its command,
// tracks outstanding transfers in order and routes each completion back.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_req/i_rw/i_addr/i_wdata : per-requester command, packed by index
//   o_gnt                     : one-hot accept strobe
//   o_rsp_valid/o_rsp_rdata/o_rsp_err : one-hot response with shared data/error
//   o_m_req/o_m_rw/o_m_addr/o_m_wdata, i_m_ready : command toward master queue
//   i_m_done/i_m_rdata/i_m_err : completion from master
//   o_outst     : outstanding-transfer count
//   o_unexp_rsp : sticky, completion seen with nothing outstanding
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH = APB_DATA_WIDTH,
  parameter int MAX_OUTST  = 4
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [NUM_REQ-1:0]              i_req,
  input  logic [NUM_REQ-1:0]              i_rw,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   i_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   i_wdata,
  output logic [NUM_REQ-1:0]              o_gnt,
  output logic [NUM_REQ-1:0]              o_rsp_valid,
  output logic [DATA_WIDTH-1:0]           o_rsp_rdata,
  output logic                            o_rsp_err,
  output logic                            o_m_req,
  output logic                            o_m_rw,
  output logic [ADDR_WIDTH-1:0]           o_m_addr,
  output logic [DATA_WIDTH-1:0]           o_m_wdata,
  input  logic                            i_m_ready,
  input  logic                            i_m_done,
  input  logic [DATA_WIDTH-1:0]           i_m_rdata,
  input  logic                            i_m_err,
  output logic [$clog2(MAX_OUTST):0]      o_outst,
  output logic                            o_unexp_rsp
);

  localparam int IW = idx_width(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic [IW-1:0]      r_rr_ptr;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic               r_rsp_err;
  logic               r_unexp_rsp;

  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_head;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic               w_accept;
  logic               w_pop;

  // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int k;
    logic found;
    k     = 0;
    found = 1'b0;
    w_win = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(r_rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!found && i_req[k]) begin
        found = 1'b1;
        w_win = IW'(k);
      end
    end
  end

  // Winner's fields; looped compare keeps the select legal for any NUM_REQ.
  always_comb begin
    o_m_rw    = 1'b0;
    o_m_addr  = '0;
    o_m_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == IW'(k)) begin
        o_m_rw    = i_rw[k];
        o_m_addr  = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        o_m_wdata = i_wdata[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Reset gating keeps the request quiet while the block is held in reset.
  assign o_m_req  = i_reset & (|i_req) & (w_count < CW'(MAX_OUTST));
  assign w_accept = o_m_req & i_m_ready;
  assign o_gnt    = w_accept ? (NUM_REQ'(1) << w_win) : '0;
  assign w_pop    = i_m_done & ~w_empty;

  apb_id_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IW)
  ) u_id_fifo (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (w_accept),
    .i_push_data (w_win),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_rr_ptr    <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_unexp_rsp <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rr_ptr <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + IW'(1);
      end
      r_rsp_valid <= w_pop ? (NUM_REQ'(1) << w_head) : '0;
      // Read data is forwarded for writes too; requesters ignore it then.
      if (w_pop) begin
        r_rsp_rdata <= i_m_rdata;
        r_rsp_err   <= i_m_err;
      end
      if (i_m_done && w_empty) r_unexp_rsp <= 1'b1;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_unexp_rsp = r_unexp_rsp;
  assign o_outst     = w_count;

  // Full flag is implied by the count compare above.
  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb/tb_apb_req_arbiter.sv - scoreboard bench for apb_req_arbiter
module tb_apb_req_arbiter;
  import apb_pkg::*;

  localparam int NR = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rstn;
  logic [NR-1:0]     req;
  logic [NR-1:0]     rw;
  logic [NR*AW-1:0]  addr_bus;
  logic [NR*DW-1:0]  wdata_bus;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [2:0]        outst;
  logic              unexp;

  apb_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  apb_req_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTST(MO)
  ) dut (
    .i_clock     (clk),
    .i_reset     (rstn),
    .i_req       (req),
    .i_rw        (rw),
    .i_addr      (addr_bus),
    .i_wdata     (wdata_bus),
    .o_gnt       (gnt),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err),
    .o_m_req     (bus.m_req),
    .o_m_rw      (bus.m_rw),
    .o_m_addr    (bus.m_addr),
    .o_m_wdata   (bus.m_wdata),
    .i_m_ready   (bus.m_ready),
    .i_m_done    (bus.m_done),
    .i_m_rdata   (bus.m_rdata),
    .i_m_err     (bus.m_err),
    .o_outst     (outst),
    .o_unexp_rsp (unexp)
  );

  typedef struct {
    int          due;
    int          id;
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  logic [AW-1:0] a_arr [NR];
  logic [DW-1:0] d_arr [NR];

  int   m_q[$];
  int   m_ptr;
  bit   m_unexp;
  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int model_winner(input logic [NR-1:0] r);
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (m_ptr + i) % NR;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // One bus cycle: drive after the edge, check and advance the model at the falling edge.
  task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] w, input logic rdy,
                       input logic dn, input logic [DW-1:0] rd, input logic er,
                       output logic [NR-1:0] g_exp);
    int  win;
    bit  exp_mreq;
    @(posedge clk);
    #1;
    req = r;
    rw  = w;
    for (int k = 0; k < NR; k++) begin
      addr_bus[k*AW +: AW]  = a_arr[k];
      wdata_bus[k*DW +: DW] = d_arr[k];
    end
    bus.m_ready = rdy;
    bus.m_done  = dn;
    bus.m_rdata = rd;
    bus.m_err   = er;
    @(negedge clk);
    chk("outst", 64'(outst), 64'(m_q.size()));
    chk("unexp", 64'(unexp), 64'(m_unexp));
    win      = model_winner(r);
    exp_mreq = (r != 0) && (m_q.size() < MO);
    chk("m_req", 64'(bus.m_req), 64'(exp_mreq));
    if (exp_mreq) begin
      chk("m_addr", 64'(bus.m_addr), 64'(a_arr[win]));
      chk("m_rw", 64'(bus.m_rw), 64'(w[win]));
      chk("m_wdata", 64'(bus.m_wdata), 64'(d_arr[win]));
    end
    g_exp = (exp_mreq && rdy) ? NR'(1 << win) : '0;
    chk("gnt", 64'(gnt), 64'(g_exp));
    if (dn) begin
      if (m_q.size() > 0) begin
        exp_t e;
        e.due   = cyc + 1;
        e.id    = m_q.pop_front();
        e.rdata = rd;
        e.err   = er;
        sb.push_back(e);
      end else begin
        m_unexp = 1'b1;
      end
    end
    if (g_exp != 0) begin
      m_q.push_back(win);
      m_ptr = (win + 1) % NR;
    end
  endtask

  // Monitor: every response the DUT presents must match the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1 << e.id));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end else if (rsp_valid != 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_spurious: got 0x%0h, expected 0x0 (cycle %0d)", rsp_valid, cyc);
      end
    end
  end

  task automatic do_reset();
    sb.delete();
    @(posedge clk);
    #1;
    rstn        = 1'b0;
    req         = '1;
    bus.m_ready = 1'b1;
    bus.m_done  = 1'b0;
    @(negedge clk);
    chk("rst_outst", 64'(outst), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_m_req", 64'(bus.m_req), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_unexp", 64'(unexp), 64'd0);
    m_q.delete();
    m_ptr   = 0;
    m_unexp = 1'b0;
    @(posedge clk);
    #1;
    req  = '0;
    rstn = 1'b1;
  endtask

  task automatic drain();
    logic [NR-1:0] g;
    for (int n = 0; n < MO + 2 && m_q.size() > 0; n++)
      drive('0, '0, 1'b0, 1'b1, DW'($urandom), 1'($urandom), g);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
  endtask

  initial begin
    logic [NR-1:0] g;
    logic [NR-1:0] pend;
    logic [NR-1:0] rwv;
    int            fair_exp [5];
    checks = 0;
    errors = 0;
    m_ptr  = 0;
    m_unexp = 1'b0;
    rstn = 1'b0;
    req = '0; rw = '0; addr_bus = '0; wdata_bus = '0;
    bus.m_ready = 1'b0; bus.m_done = 1'b0; bus.m_rdata = '0; bus.m_err = 1'b0;
    for (int k = 0; k < NR; k++) begin
      a_arr[k] = AW'($urandom);
      d_arr[k] = DW'($urandom);
    end

    do_reset();

    // Fairness: all requesting, completion every cycle after the first.
    fair_exp = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 4'b0101, 1'b1, (i != 0), DW'($urandom), 1'b0, g);
      chk("fair_gnt", 64'(gnt), 64'(1 << fair_exp[i]));
    end
    drain();

    // Single request from requester 1.
    a_arr[1] = 16'h0040;
    drive(4'b0010, 4'b0010, 1'b1, 1'b0, '0, 1'b0, g);
    chk("single_gnt", 64'(gnt), 64'h2);
    chk("single_addr", 64'(bus.m_addr), 64'h0040);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("single_outst", 64'(outst), 64'd1);
    drain();

    // Full stall: four accepts, then blocked until one completion.
    for (int i = 0; i < MO; i++) drive(4'b1111, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    chk("full_m_req", 64'(bus.m_req), 64'd0);
    chk("full_gnt", 64'(gnt), 64'd0);
    drive(4'b1111, 4'b0000, 1'b1, 1'b1, 16'h5555, 1'b0, g);
    chk("full_done_gnt", 64'(gnt), 64'd0);
    drive(4'b1111, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    chk("full_resume_m_req", 64'(bus.m_req), 64'd1);
    chk("full_resume_outst", 64'(outst), 64'd3);
    drain();

    // Routing: requester 2 then 0, completions returned in that order.
    drive(4'b0100, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    drive(4'b0001, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    drive('0, '0, 1'b0, 1'b1, 16'hBEEF, 1'b0, g);
    drive('0, '0, 1'b0, 1'b1, 16'h1234, 1'b1, g);
    chk("route0_valid", 64'(rsp_valid), 64'h4);
    chk("route0_rdata", 64'(rsp_rdata), 64'hBEEF);
    chk("route0_err", 64'(rsp_err), 64'd0);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("route1_valid", 64'(rsp_valid), 64'h1);
    chk("route1_rdata", 64'(rsp_rdata), 64'h1234);
    chk("route1_err", 64'(rsp_err), 64'd1);

    // Unexpected completion with nothing outstanding.
    drive('0, '0, 1'b0, 1'b1, 16'hDEAD, 1'b0, g);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("unexp_set", 64'(unexp), 64'd1);
    chk("unexp_no_rsp", 64'(rsp_valid), 64'd0);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("unexp_sticky", 64'(unexp), 64'd1);

    // Reset with two transfers in flight.
    drive(4'b0110, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    drive(4'b0110, 4'b0000, 1'b1, 1'b0, '0, 1'b0, g);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("mid_outst_before", 64'(outst), 64'd2);
    do_reset();
    drive(4'b1000, 4'b1000, 1'b1, 1'b0, '0, 1'b0, g);
    chk("mid_gnt", 64'(gnt), 64'h8);
    drain();
    drive('0, '0, 1'b0, 1'b1, 16'h0bad, 1'b0, g);
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("mid_unexp_after", 64'(unexp), 64'd1);

    // Randomized traffic: requests held until granted, occasional drops.
    do_reset();
    pend = '0;
    rwv  = '0;
    repeat (1500) begin
      for (int k = 0; k < NR; k++) begin
        if (!pend[k] && $urandom_range(0, 3) == 0) begin
          pend[k]  = 1'b1;
          rwv[k]   = 1'($urandom);
          a_arr[k] = AW'($urandom);
          d_arr[k] = DW'($urandom);
        end else if (pend[k] && $urandom_range(0, 31) == 0) begin
          pend[k] = 1'b0;
        end
      end
      drive(pend, rwv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
            DW'($urandom), 1'($urandom), g);
      pend = pend & ~g;
    end
    drain();
    drive('0, '0, 1'b0, 1'b0, '0, 1'b0, g);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_req_arbiter.md
APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 4: requester count, 2..8.
- ADDR_WIDTH, 16: address width.
- DATA_WIDTH, 16: data width.
- MAX_OUTST, 4: maximum accepted-but-unanswered transfers, power of 2.

REQ-002 Ports SHALL be:
- i_clock  in  1  clock.
- i_reset  in  1  reset, asynchronous, active-low.
- i_req  in  NUM_REQ  per-requester request, held until granted.
- i_rw  in  NUM_REQ  per-requester direction, 1=write.
- i_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at slice k.
- i_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- o_gnt  out  NUM_REQ  one-hot accept strobe.
- o_rsp_valid  out  NUM_REQ  one-hot response strobe.
- o_rsp_rdata  out  DATA_WIDTH  response read data, shared.
- o_rsp_err  out  1  response slave error, shared.
- o_m_req  out  1  request to APB master command queue.
- o_m_rw  out  1  forwarded direction.
- o_m_addr  out  ADDR_WIDTH  forwarded address.
- o_m_wdata  out  DATA_WIDTH  forwarded write data.
- i_m_ready  in  1  master queue can accept.
- i_m_done  in  1  master transfer-complete pulse.
- i_m_rdata  in  DATA_WIDTH  master read data.
- i_m_err  in  1  master PSLVERR.
- o_outst  out  $clog2(MAX_OUTST)+1  outstanding-transfer count.
- o_unexp_rsp  out  1  sticky: done pulse received with nothing outstanding.

Function
REQ-003 Arbitration SHALL be combinational round-robin: the winner is the first requester with i_req=1 searched from pointer rr_ptr upward, wrapping modulo NUM_REQ.
REQ-004 o_m_req SHALL equal (any i_req) AND (o_outst < MAX_OUTST); o_m_rw, o_m_addr and o_m_wdata SHALL carry the winner's fields in the same cycle.
REQ-005 Accept SHALL occur when o_m_req=1 and i_m_ready=1. o_gnt SHALL then be one-hot on the winner in the same cycle, and all zero otherwise.
REQ-006 On accept, rr_ptr SHALL become (winner+1) mod NUM_REQ. Without an accept, rr_ptr SHALL hold.
REQ-007 On accept, the winner index SHALL be pushed into an in-order ID queue of depth MAX_OUTST.
REQ-008 Push SHALL be blocked when the queue is full, including in a cycle with a simultaneous pop.
REQ-009 On i_m_done with the queue non-empty:
- the queue head SHALL be popped;
- the next cycle, o_rsp_valid SHALL be one-hot on the popped index for exactly one cycle;
- o_rsp_rdata and o_rsp_err SHALL carry the registered i_m_rdata and i_m_err in that cycle.
REQ-010 On i_m_done with the queue empty: no pop, o_rsp_valid stays zero, o_unexp_rsp SHALL set and hold until reset.
REQ-011 Simultaneous push and pop (queue not full) SHALL leave o_outst unchanged and keep FIFO order.
REQ-012 Queue pointers SHALL wrap modulo MAX_OUTST. o_outst SHALL be exact over 0..MAX_OUTST.
REQ-013 o_rsp_rdata SHALL be forwarded for writes as well. Requesters ignore it for writes.
REQ-014 A requester dropping i_req before grant SHALL simply lose arbitration; no state change.

Reset
REQ-015 While i_reset=0 the block SHALL hold:
- rr_ptr=0, queue empty, o_outst=0;
- o_rsp_valid=0, o_rsp_rdata=0, o_rsp_err=0;
- o_unexp_rsp=0, o_gnt=0, o_m_req=0.
REQ-016 Reset mid-operation SHALL discard all outstanding IDs. Responses arriving after reset SHALL be treated per REQ-010.

Structure
REQ-017 A shared package apb_pkg SHALL hold:
- the default ADDR_WIDTH and DATA_WIDTH constants;
- the requester-index width function.
REQ-018 The ID queue SHALL be one sub-module, apb_id_fifo, with push, pop, full, empty and count.
REQ-019 Arbitration, pointer and response registers SHALL reside in the top module. The RTL SHALL be 120-400 lines.

Verification
REQ-020 The bench SHALL cover:
- Single request: i_req=4'b0010, addr 0x0040, rw=1, i_m_ready=1 -> o_gnt=4'b0010 same cycle, o_m_addr=0x0040, o_outst=1.
- Fairness: i_req=4'b1111 held, i_m_ready=1, done every cycle -> grants 0,1,2,3,0 in consecutive accepts.
- Full stall: MAX_OUTST=4, four accepts, no done -> o_m_req=0, o_gnt=0 until one i_m_done, then accept next cycle.
- Routing: accepts from requesters 2 then 0, done with rdata 0xBEEF/err=0 then 0x1234/err=1 -> o_rsp_valid 4'b0100 with 0xBEEF, then 4'b0001 with 0x1234, err=1.
- Unexpected done: i_m_done with o_outst=0 -> o_unexp_rsp=1 sticky, no o_rsp_valid.
- Reset mid-flight: two outstanding, assert i_reset -> o_outst=0, rr_ptr=0; next i_req=4'b1000 granted first.
